// File: rtl/fpu_addsub_hs_pkg.sv
// rtl/fpu_addsub_hs_pkg.sv - shared types and constants for the add/subtract unit
// Contents: rounding-mode codes, FSM state encoding, quiet-NaN pattern builder.
package fpu_pkg;

  localparam logic [1:0] RM_RNE = 2'b00;  // nearest, ties to even
  localparam logic [1:0] RM_RTZ = 2'b01;  // toward zero
  localparam logic [1:0] RM_RUP = 2'b10;  // toward +inf
  localparam logic [1:0] RM_RDN = 2'b11;  // toward -inf

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
  function automatic logic [63:0] fpu_qnan(input int unsigned w, input int unsigned w_exp,
                                           input int unsigned w_sgf);
    logic [63:0] ones;
    logic [63:0] mask;
    ones = (64'd1 << w_exp) - 64'd1;
    mask = (64'd1 << w) - 64'd1;
    return ((ones << w_sgf) | (64'd1 << (w_sgf - 1))) & mask;
  endfunction

endpackage

// File: rtl/fpu_addsub_hs_if.sv
// rtl/fpu_addsub_hs_if.sv - operand/result handshake bundle for the add/subtract unit
// Signals: in_valid/in_ready + Data_X, Data_Y, add_subt, r_mode (operand side);
//          out_valid/out_ready + final_result_ieee and four exception flags (result side).
// Modports: master = operand source / result sink, slave = the arithmetic unit.
interface fpu_addsub_hs_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] Data_X;
  logic [W-1:0] Data_Y;
  logic         add_subt;
  logic [1:0]   r_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] final_result_ieee;
  logic         overflow_flag;
  logic         underflow_flag;
  logic         invalid_flag;
  logic         inexact_flag;

  modport master (
    output in_valid, Data_X, Data_Y, add_subt, r_mode, out_ready,
    input  in_ready, out_valid, final_result_ieee,
           overflow_flag, underflow_flag, invalid_flag, inexact_flag
  );

  modport slave (
    input  in_valid, Data_X, Data_Y, add_subt, r_mode, out_ready,
    output in_ready, out_valid, final_result_ieee,
           overflow_flag, underflow_flag, invalid_flag, inexact_flag
  );
endinterface

// File: rtl/fpu_addsub_hs_lzc_sgf.sv
// rtl/fpu_addsub_hs_lzc_sgf.sv - combinational leading-zero counter over the extended significand
// Ports: data_i  [W_Sgf+4] hidden bit, fraction, guard/round/sticky
//        count_o          number of leading zeros (W_Sgf+4 when data_i is zero)
module lzc_sgf #(
  parameter  int W_Sgf = 23,
  localparam int N     = W_Sgf + 4,
  localparam int CW    = $clog2(N + 1)
) (
  input  logic [N-1:0]  data_i,
  output logic [CW-1:0] count_o
);

  // Scan upward so the highest set bit writes last and wins.
  always_comb begin
    count_o = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (data_i[i]) count_o = CW'(N - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_addsub_hs.sv
// rtl/fpu_addsub_hs.sv - multi-cycle IEEE-754 add/subtract with valid/ready handshakes
// Ports: clk (rising edge), rst (async, active-low),
//        bus (slave modport): operands in on in_valid&in_ready, result and flags
//        held on out_valid until out_ready.
// Sequence: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE; special operands
// skip from UNPACK to DONE. out_valid is registered one cycle after entering DONE.
module fpu_addsub_hs
  import fpu_pkg::*;
#(
  parameter int W     = 32,
  parameter int W_Exp = 8,
  parameter int W_Sgf = 23
) (
  input logic            clk,
  input logic            rst,
  fpu_addsub_hs_if.slave bus
);

  localparam int E  = W_Exp + 2;          // signed exponent width, never wraps
  localparam int M  = W_Sgf + 4;          // hidden + fraction + guard/round/sticky
  localparam int CW = $clog2(M + 1);
  localparam logic [W-1:0]         QNAN     = W'(fpu_qnan(W, W_Exp, W_Sgf));
  localparam logic [W_Exp-1:0]     EXP_ONES = '1;
  localparam logic [W_Exp-1:0]     EXP_TOPF = EXP_ONES - 1'b1;
  localparam logic [W_Exp-1:0]     SH_MAX   = W_Exp'(W_Sgf + 3);
  localparam logic signed [E-1:0]  EXP_ONE  = 1;
  localparam logic signed [E-1:0]  EXP_MAX  = {2'b00, EXP_ONES};

  state_t state_q, state_d;
  logic [W-1:0] x_q, y_q, res_q;
  logic [1:0]   rm_q;
  logic         sub_q, sign_q, eff_sub_q, zero_q, out_valid_q;
  logic         ovf_q, unf_q, inv_q, inx_q;
  logic signed [E-1:0] exp_q;
  logic [M-1:0] sig_a_q, sig_b_q, norm_q;
  logic [M:0]   sum_q;

  // Operand fields; sy is Y's sign after folding in the requested operation.
  logic [W_Exp-1:0] ex, ey, big_e, small_e, diff, sh;
  logic [W_Sgf-1:0] fx, fy, big_f, small_f;
  logic sx, sy, x_zero, y_zero, x_max, y_max, x_nan, y_nan, x_inf, y_inf, special, y_big;
  assign ex = x_q[W-2:W_Sgf];
  assign ey = y_q[W-2:W_Sgf];
  assign fx = x_q[W_Sgf-1:0];
  assign fy = y_q[W_Sgf-1:0];
  assign sx = x_q[W-1];
  assign sy = y_q[W-1] ^ sub_q;
  assign x_zero = (ex == '0);
  assign y_zero = (ey == '0);
  assign x_max  = (ex == EXP_ONES);
  assign y_max  = (ey == EXP_ONES);
  assign x_nan  = x_max & (|fx);
  assign y_nan  = y_max & (|fy);
  assign x_inf  = x_max & ~(|fx);
  assign y_inf  = y_max & ~(|fy);
  assign special = x_max | y_max | x_zero | y_zero;

  logic [W-1:0] spec_res;
  logic         spec_inv;
  always_comb begin
    spec_res = '0;
    spec_inv = 1'b0;
    if (x_nan | y_nan) begin
      spec_res = QNAN;
      spec_inv = (x_nan & ~fx[W_Sgf-1]) | (y_nan & ~fy[W_Sgf-1]);
    end else if (x_inf & y_inf & (sx != sy)) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if (x_inf) begin
      spec_res = {sx, x_q[W-2:0]};
    end else if (y_inf) begin
      spec_res = {sy, y_q[W-2:0]};
    end else if (x_zero & y_zero) begin
      spec_res = {(rm_q == RM_RDN) ? (sx | sy) : (sx & sy), {(W-1){1'b0}}};
    end else if (x_zero) begin
      spec_res = {sy, y_q[W-2:0]};
    end else begin
      spec_res = {sx, x_q[W-2:0]};
    end
  end

  // Alignment: larger magnitude becomes operand A; B is shifted right with the
  // spilled-out bits folded into its sticky position.
  logic [2*M-1:0] wide;
  logic [M-1:0]   aligned;
  assign y_big   = y_q[W-2:0] > x_q[W-2:0];
  assign big_e   = y_big ? ey : ex;
  assign small_e = y_big ? ex : ey;
  assign big_f   = y_big ? fy : fx;
  assign small_f = y_big ? fx : fy;
  assign diff    = big_e - small_e;
  assign sh      = (diff > SH_MAX) ? SH_MAX : diff;
  assign wide    = {1'b1, small_f, 3'b000, {M{1'b0}}} >> sh;
  assign aligned = {wide[2*M-1:M+1], wide[M] | (|wide[M-1:0])};

  logic [M:0] sum_d;
  assign sum_d = eff_sub_q ? ({1'b0, sig_a_q} - {1'b0, sig_b_q})
                           : ({1'b0, sig_a_q} + {1'b0, sig_b_q});

  logic [CW-1:0]       lz;
  logic signed [E-1:0] lz_ext, norm_exp_d;
  logic [M-1:0]        norm_d;
  lzc_sgf #(.W_Sgf(W_Sgf)) u_lzc (.data_i(sum_q[M-1:0]), .count_o(lz));
  assign lz_ext = {{(E-CW){1'b0}}, lz};

  always_comb begin
    norm_d     = '0;
    norm_exp_d = exp_q;
    if (sum_q[M]) begin
      norm_d     = {sum_q[M:2], sum_q[1] | sum_q[0]};
      norm_exp_d = exp_q + EXP_ONE;
    end else begin
      norm_d     = sum_q[M-1:0] << lz;
      norm_exp_d = exp_q - lz_ext;
    end
  end

  // Rounding on norm_q: [M-1]=hidden, [M-2:3]=fraction, [2]=guard, [1]=round, [0]=sticky.
  logic [W_Sgf+1:0]    mant;
  logic signed [E-1:0] exp_r, carry_inc;
  logic [W-1:0]        rnd_res;
  logic up, inexact, to_inf, rnd_ovf, rnd_unf, rnd_inx;
  always_comb begin
    rnd_res = '0;
    rnd_ovf = 1'b0;
    rnd_unf = 1'b0;
    rnd_inx = 1'b0;
    inexact = |norm_q[2:0];
    case (rm_q)
      RM_RNE:  up = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
      RM_RTZ:  up = 1'b0;
      RM_RUP:  up = inexact & ~sign_q;
      default: up = inexact & sign_q;
    endcase
    mant      = {1'b0, norm_q[M-1:3]} + {{(W_Sgf+1){1'b0}}, up};
    carry_inc = {{(E-1){1'b0}}, mant[W_Sgf+1]};
    exp_r     = exp_q + carry_inc;
    to_inf    = (rm_q == RM_RNE) | ((rm_q == RM_RUP) & ~sign_q) | ((rm_q == RM_RDN) & sign_q);
    if (zero_q) begin
      rnd_res = {rm_q == RM_RDN, {(W-1){1'b0}}};
    end else if (exp_q < EXP_ONE) begin
      rnd_res = {sign_q, {(W-1){1'b0}}};
      rnd_unf = 1'b1;
      rnd_inx = 1'b1;
    end else if (exp_r >= EXP_MAX) begin
      rnd_res = to_inf ? {sign_q, EXP_ONES, {W_Sgf{1'b0}}} : {sign_q, EXP_TOPF, {W_Sgf{1'b1}}};
      rnd_ovf = 1'b1;
      rnd_inx = 1'b1;
    end else begin
      // On a rounding carry the fraction field is all zeros either way.
      rnd_res = {sign_q, exp_r[W_Exp-1:0],
                 mant[W_Sgf+1] ? mant[W_Sgf:1] : mant[W_Sgf-1:0]};
      rnd_inx = inexact;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.in_valid) state_d = S_UNPACK;
      S_UNPACK: state_d = special ? S_DONE : S_ALIGN;
      S_ALIGN:  state_d = S_ADD;
      S_ADD:    state_d = S_NORM;
      S_NORM:   state_d = S_ROUND;
      S_ROUND:  state_d = S_DONE;
      S_DONE:   if (out_valid_q & bus.out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      x_q <= '0;  y_q <= '0;  sub_q <= 1'b0;  rm_q <= RM_RNE;
      res_q <= '0;  out_valid_q <= 1'b0;
      ovf_q <= 1'b0;  unf_q <= 1'b0;  inv_q <= 1'b0;  inx_q <= 1'b0;
      sign_q <= 1'b0;  eff_sub_q <= 1'b0;  zero_q <= 1'b0;  exp_q <= '0;
      sig_a_q <= '0;  sig_b_q <= '0;  sum_q <= '0;  norm_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (bus.in_valid) begin
          x_q <= bus.Data_X;  y_q <= bus.Data_Y;
          sub_q <= bus.add_subt;  rm_q <= bus.r_mode;
          res_q <= '0;
          ovf_q <= 1'b0;  unf_q <= 1'b0;  inv_q <= 1'b0;  inx_q <= 1'b0;
        end
        S_UNPACK: if (special) begin
          res_q <= spec_res;
          inv_q <= spec_inv;
        end
        S_ALIGN: begin
          sign_q    <= y_big ? sy : sx;
          eff_sub_q <= sx ^ sy;
          exp_q     <= {2'b00, big_e};
          sig_a_q   <= {1'b1, big_f, 3'b000};
          sig_b_q   <= aligned;
        end
        S_ADD:  sum_q <= sum_d;
        S_NORM: begin
          norm_q <= norm_d;
          exp_q  <= norm_exp_d;
          zero_q <= (sum_q == '0);
        end
        S_ROUND: begin
          res_q <= rnd_res;
          ovf_q <= rnd_ovf;  unf_q <= rnd_unf;  inx_q <= rnd_inx;
        end
        S_DONE: begin
          if (!out_valid_q)        out_valid_q <= 1'b1;
          else if (bus.out_ready)  out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready          = (state_q == S_IDLE);
  assign bus.out_valid         = out_valid_q;
  assign bus.final_result_ieee = res_q;
  assign bus.overflow_flag     = ovf_q;
  assign bus.underflow_flag    = unf_q;
  assign bus.invalid_flag      = inv_q;
  assign bus.inexact_flag      = inx_q;

endmodule

// File: tb/tb_fpu_addsub_hs.sv
// tb/tb_fpu_addsub_hs.sv - scoreboard bench for fpu_addsub_hs with directed vectors
module tb_fpu_addsub_hs;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fpu_addsub_hs_if #(.W(32)) itf ();
  fpu_addsub_hs #(.W(32), .W_Exp(8), .W_Sgf(23)) dut (.clk(clk), .rst(rst), .bus(itf));

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [3:0]  flags;   // {overflow, underflow, invalid, inexact}
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int pcnt = 0;
  logic prev_valid = 1'b0, hold_pending = 1'b0, after_hs = 1'b0;
  logic [31:0] held_res;
  logic [3:0]  held_flags;
  logic [3:0]  dut_flags;

  assign dut_flags = {itf.overflow_flag, itf.underflow_flag, itf.invalid_flag, itf.inexact_flag};

  always @(posedge clk) pcnt <= pcnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // Monitor: samples on the falling edge; a valid&ready seen here completes on the next rise.
  always @(negedge clk) begin
    if (!rst) begin
      prev_valid   = 1'b0;
      hold_pending = 1'b0;
      after_hs     = 1'b0;
    end else begin
      if (after_hs) begin
        chk("in_ready_after_handshake", {31'd0, itf.in_ready}, 32'd1);
        after_hs = 1'b0;
      end
      if (itf.out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output: got %h expected no result", itf.final_result_ieee);
        end else begin
          if (!prev_valid)
            chk({sb[0].name, "_latency"}, pcnt - sb[0].acc, sb[0].lat);
          if (hold_pending) begin
            chk({sb[0].name, "_hold_result"}, itf.final_result_ieee, held_res);
            chk({sb[0].name, "_hold_flags"}, {28'd0, dut_flags}, {28'd0, held_flags});
          end
          chk({sb[0].name, "_in_ready_busy"}, {31'd0, itf.in_ready}, 32'd0);
          if (itf.out_ready) begin
            chk({sb[0].name, "_result"}, itf.final_result_ieee, sb[0].res);
            chk({sb[0].name, "_flags"}, {28'd0, dut_flags}, {28'd0, sb[0].flags});
            void'(sb.pop_front());
            after_hs     = 1'b1;
            hold_pending = 1'b0;
          end else begin
            held_res     = itf.final_result_ieee;
            held_flags   = dut_flags;
            hold_pending = 1'b1;
          end
        end
      end
      prev_valid = itf.out_valid;
    end
  end

  // Called in the posedge+1 phase; returns in the same phase just after the accept edge.
  task automatic send(input string nm, input logic [31:0] x, input logic [31:0] y,
                      input logic sub, input logic [1:0] rm, input logic [31:0] er,
                      input logic [3:0] ef, input int lat);
    int n;
    exp_t e;
    n = 0;
    while (!itf.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!itf.in_ready) begin
      chk({nm, "_in_ready_timeout"}, {31'd0, itf.in_ready}, 32'd1);
      return;
    end
    itf.in_valid = 1'b1;
    itf.Data_X   = x;
    itf.Data_Y   = y;
    itf.add_subt = sub;
    itf.r_mode   = rm;
    @(posedge clk); #1;
    e.name = nm;  e.res = er;  e.flags = ef;  e.lat = lat;  e.acc = pcnt;
    sb.push_back(e);
    itf.in_valid = 1'b0;
    itf.Data_X   = $urandom;
    itf.Data_Y   = $urandom;
    itf.add_subt = 1'($urandom);
    itf.r_mode   = 2'($urandom);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_drained"}, sb.size(), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    itf.in_valid  = 1'b0;
    itf.Data_X    = '0;
    itf.Data_Y    = '0;
    itf.add_subt  = 1'b0;
    itf.r_mode    = 2'b00;
    itf.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, itf.in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, itf.out_valid}, 32'd0);
    chk("reset_result", itf.final_result_ieee, 32'd0);
    chk("reset_flags", {28'd0, dut_flags}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    send("add_1_2",     32'h3F800000, 32'h40000000, 1'b0, 2'b00, 32'h40400000, 4'b0000, 6);
    send("sub_eq_rne",  32'h3F800000, 32'h3F800000, 1'b1, 2'b00, 32'h00000000, 4'b0000, 6);
    send("sub_eq_rdn",  32'h3F800000, 32'h3F800000, 1'b1, 2'b11, 32'h80000000, 4'b0000, 6);
    send("tie_rne",     32'h3F800000, 32'h33800000, 1'b0, 2'b00, 32'h3F800000, 4'b0001, 6);
    send("tie_rup",     32'h3F800000, 32'h33800000, 1'b0, 2'b10, 32'h3F800001, 4'b0001, 6);
    send("above_half",  32'h3F800000, 32'h33800001, 1'b0, 2'b00, 32'h3F800001, 4'b0001, 6);
    send("ovf_rne",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00, 32'h7F800000, 4'b1001, 6);
    send("ovf_rtz",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b01, 32'h7F7FFFFF, 4'b1001, 6);
    send("neg1_plus_h", 32'hBF800000, 32'h3F000000, 1'b0, 2'b00, 32'hBF000000, 4'b0000, 6);
    send("inf_m_inf",   32'h7F800000, 32'h7F800000, 1'b1, 2'b00, 32'h7FC00000, 4'b0010, 2);
    send("snan_in",     32'h7FA00000, 32'h3F800000, 1'b0, 2'b00, 32'h7FC00000, 4'b0010, 2);
    send("qnan_in",     32'h7FC00001, 32'h3F800000, 1'b0, 2'b00, 32'h7FC00000, 4'b0000, 2);
    send("ninf_p_1",    32'hFF800000, 32'h3F800000, 1'b0, 2'b00, 32'hFF800000, 4'b0000, 2);
    send("nz_p_nz",     32'h80000000, 32'h80000000, 1'b0, 2'b00, 32'h80000000, 4'b0000, 2);
    send("z_m_z_rne",   32'h00000000, 32'h00000000, 1'b1, 2'b00, 32'h00000000, 4'b0000, 2);
    send("z_m_z_rdn",   32'h00000000, 32'h00000000, 1'b1, 2'b11, 32'h80000000, 4'b0000, 2);
    send("underflow",   32'h00800001, 32'h00800000, 1'b1, 2'b00, 32'h00000000, 4'b0101, 6);
    drain("vectors");

    // Backpressure: result held for 10 cycles while a new request waits unaccepted.
    itf.out_ready = 1'b0;
    send("backpressure", 32'h3F800000, 32'h40000000, 1'b0, 2'b00, 32'h40400000, 4'b0000, 6);
    n = 0;
    while (!itf.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_out_valid", {31'd0, itf.out_valid}, 32'd1);
    itf.in_valid = 1'b1;
    itf.Data_X   = 32'h40000000;
    itf.Data_Y   = 32'h40000000;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_in_ready_held", {31'd0, itf.in_ready}, 32'd0);
    itf.in_valid  = 1'b0;
    itf.out_ready = 1'b1;
    drain("backpressure");

    // Reset during NORM: the aborted operation must never produce a result.
    send("abort", 32'h3F800000, 32'h40000000, 1'b0, 2'b00, 32'h40400000, 4'b0000, 6);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    #1;
    chk("abort_in_ready", {31'd0, itf.in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, itf.out_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send("after_abort", 32'h3F800000, 32'h40000000, 1'b0, 2'b00, 32'h40400000, 4'b0000, 6);
    drain("after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
